icu_refill_ctrl: RTL
====================

// Module: icu_refill_ctrl
// PURPOSE
//  I-cache miss refill sequencer. Takes a miss reported by the ic2 lookup stage
//  and fetches the line from the BIU in BEATS x 64-bit beats. Writes each beat
//  into the data RAM and then writes the tag/valid entry.
//  Can forward the missed doubleword to the IFU (critical-word bypass).
// PARAMETERS
//  IDX_W  7  set-index width; tag width TAG_W = 27-IDX_W (default 20)
//  BEATS  4  beats per line, 64b each (32B line); fixed at 4, addr[4:3] = word
// PORTS
//  clk                in   1        clock, all state on rising edge
//  resetn             in   1        async active-low reset
//  ic2_miss           in   1        miss pulse from ic2 lookup
//  ic2_miss_addr      in   29       miss doubleword address [31:3]
//  ifu_icu_cancel     in   1        IFU redirect; drop pending bypass
//  refill_busy        out  1        controller not IDLE; ic1 must stall
//  biu_rd_req         out  1        line read request, held until ack
//  biu_rd_addr        out  27       line address [31:5]
//  biu_rd_ack         in   1        BIU accepted request
//  biu_rd_data_valid  in   1        read beat valid
//  biu_rd_data        in   64       read beat data, line order word 0..3
//  dram_we            out  1        data RAM write enable
//  dram_addr          out  IDX_W+2  {index, beat}
//  dram_wdata         out  64       data RAM write data
//  tram_we            out  1        tag RAM write enable
//  tram_addr          out  IDX_W    tag RAM index
//  tram_wdata         out  TAG_W+1  {valid, tag[31:12]}
//  refill_data_valid  out  1        bypass doubleword valid (1-cycle pulse)
//  refill_data        out  64       bypass doubleword
//  refill_done        out  1        line installed (1-cycle pulse)
// BEHAVIOUR
//  Reset (async): state=IDLE, beat cnt=0, cancel flag=0, addr latch=0.
//   All outputs are 0 during reset.
//  FSM IDLE->REQ->FILL->TAG->IDLE:
//   IDLE: if ic2_miss, latch ic2_miss_addr and go to REQ. A miss in any other
//    state is ignored; the upstream stage holds it until refill_busy=0.
//   REQ: biu_rd_req=1, biu_rd_addr=latched[31:5]. On biu_rd_ack go to FILL
//    next cycle. Request is asserted the cycle after the miss.
//   FILL: each biu_rd_data_valid beat gives dram_we=1 in the same cycle,
//    with dram_addr={idx,cnt} and dram_wdata=biu_rd_data; then cnt++.
//    Valid low: cnt holds, no write. biu_rd_data_valid outside FILL is ignored.
//    The beat with cnt==BEATS-1 moves to TAG; cnt clears to 0.
//   TAG: one cycle with tram_we=1, tram_addr=idx, tram_wdata={1'b1,tag}.
//    refill_done=1 in this cycle; go to IDLE. Earliest new miss: next cycle.
//  refill_busy = (state != IDLE); it is combinational from state.
//  Cancel: ifu_icu_cancel in REQ/FILL sets a sticky flag, cleared on entry to IDLE.
//   The refill still runs to completion (BIU protocol, line install).
//   refill_done still pulses.
//  Reset mid-operation: returns to IDLE immediately; partial line is left with
//   no tag write. The BIU must be reset together with this block.
// CONFIGURATION
//  ICU_CRIT_BYPASS_EN defined: when the FILL beat with cnt==latched[4:3] is
//   written and cancel (flag or same-cycle input) is 0, refill_data_valid=1 and
//   refill_data=that beat, registered, 1 cycle after the beat.
//  Not defined: refill_data_valid and refill_data are tied 0. The IFU re-requests
//   after refill_done and hits.
// TESTING
//  1 Miss 29'h2020, ack 2 cycles after req, beats AAAA..,BBBB..,CCCC..,DDDD..
//    -> biu_rd_addr=27'h808; dram_addr 0x20..0x23; tram_addr 7'h08,
//    tram_wdata={1,20'h00010}; refill_done once; bypass AAAA.. (EN).
//  2 Miss 29'h2023 -> bypass=DDDD.., 1 cycle after 4th beat; none earlier (EN).
//  3 Beats with 1-3 idle cycles between them -> exactly 4 dram_we, addrs in
//    order, busy held until done+1.
//  4 ifu_icu_cancel pulse during FILL -> refill_data_valid never 1;
//    tram_we and refill_done still occur.
//  5 resetn low after 2 beats -> outputs 0 at once, no tram_we; a following
//    miss 29'h4000 refills normally (biu_rd_addr=27'h1000).
//  6 Second ic2_miss during FILL/TAG -> ignored (one biu_rd_req);
//    re-asserted the cycle after done -> accepted.

Source files
------------

// File: rtl/icu_refill_ctrl.sv
// icu_refill_ctrl: I-cache miss refill sequencer (BIU line read -> data RAM beats -> tag write).
// Optional critical-word bypass to the IFU enabled by defining ICU_CRIT_BYPASS_EN.
module icu_refill_ctrl #(
    parameter int IDX_W = 7,
    parameter int BEATS = 4,
    localparam int TAG_W = 27 - IDX_W
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               ic2_miss,
    input  logic [28:0]        ic2_miss_addr,
    input  logic               ifu_icu_cancel,
    output logic               refill_busy,
    output logic               biu_rd_req,
    output logic [26:0]        biu_rd_addr,
    input  logic               biu_rd_ack,
    input  logic               biu_rd_data_valid,
    input  logic [63:0]        biu_rd_data,
    output logic               dram_we,
    output logic [IDX_W+1:0]   dram_addr,
    output logic [63:0]        dram_wdata,
    output logic               tram_we,
    output logic [IDX_W-1:0]   tram_addr,
    output logic [TAG_W:0]     tram_wdata,
    output logic               refill_data_valid,
    output logic [63:0]        refill_data,
    output logic               refill_done
);
    typedef enum logic [1:0] {IDLE, REQ, FILL, TAG} state_e;
    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        cancel_q, cancel_d;
    logic [28:0] addr_q, addr_d;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    assign idx = addr_q[IDX_W+1:2];
    assign tag = addr_q[28:IDX_W+2];
    assign refill_busy = state_q != IDLE;
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cancel_d   = cancel_q;
        addr_d     = addr_q;
        biu_rd_req = 1'b0;
        biu_rd_addr = '0;
        dram_we    = 1'b0;
        dram_addr  = '0;
        dram_wdata = '0;
        tram_we    = 1'b0;
        tram_addr  = '0;
        tram_wdata = '0;
        refill_done = 1'b0;
        case (state_q)
            IDLE: begin
                cancel_d = 1'b0;
                if (ic2_miss) begin
                    addr_d  = ic2_miss_addr;
                    state_d = REQ;
                end
            end
            REQ: begin
                biu_rd_req  = 1'b1;
                biu_rd_addr = addr_q[28:2];
                cancel_d    = cancel_q | ifu_icu_cancel;
                state_d     = biu_rd_ack ? FILL : REQ;
            end
            FILL: begin
                cancel_d = cancel_q | ifu_icu_cancel;
                if (biu_rd_data_valid) begin
                    dram_we    = 1'b1;
                    dram_addr  = {idx, cnt_q};
                    dram_wdata = biu_rd_data;
                    cnt_d      = cnt_q + 2'd1;
                    if (cnt_q == 2'(BEATS - 1)) begin
                        cnt_d   = 2'd0;
                        state_d = TAG;
                    end
                end
            end
            default: begin
                tram_we     = 1'b1;
                tram_addr   = idx;
                tram_wdata  = {1'b1, tag};
                refill_done = 1'b1;
                cancel_d    = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cancel_q <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cancel_q <= cancel_d;
            addr_q   <= addr_d;
        end
    end
`ifdef ICU_CRIT_BYPASS_EN
    logic        byp_v_q, byp_v_d;
    logic [63:0] byp_data_q, byp_data_d;
    // cancel in the same cycle as the critical beat must also suppress the forward
    always_comb begin
        byp_v_d    = dram_we && cnt_q == addr_q[1:0] && !cancel_q && !ifu_icu_cancel;
        byp_data_d = byp_v_d ? biu_rd_data : '0;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            byp_v_q    <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_v_q    <= byp_v_d;
            byp_data_q <= byp_data_d;
        end
    end
    assign refill_data_valid = byp_v_q;
    assign refill_data       = byp_data_q;
`else
    logic unused_crit;
    assign unused_crit       = ^addr_q[1:0];
    assign refill_data_valid = 1'b0;
    assign refill_data       = '0;
`endif
endmodule
